core_run_ctrl: RTL and testbench

- Parametrised multi-core run controller.
- Sequences memory ownership between the IO loader and N_CORES cores: load phase, reset-hold phase, run phase, done phase.
- Per-core reset gating under a participation mask; sticky per-core completion detection; saturating run-cycle counter.
- Sits between the IO/loader subsystem, the instruction/data memory muxes and the cores' reset/enable inputs.

---
 rtl/core_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_core_run_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Multi-core run controller: hands the memories from the loader to the cores and sequences LOAD/HOLD/RUN/DONE.
// Latency: outputs decode from registered state, so every effect shows the cycle after the transition edge.
// Backpressure: none; start/abort are levels, and DONE waits for start to drop before returning to LOAD.
module core_run_ctrl #(
  parameter int N_CORES  = 1,
  parameter int STATUS_W = 32,
  parameter int RST_HOLD = 4,
  parameter int CYC_W    = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_CORES-1:0]          core_mask,
  input  logic [N_CORES-1:0]          core_en_instr_mem,
  input  logic [N_CORES*STATUS_W-1:0] core_status,
  output logic                        rst,
  output logic                        instr_sel,
  output logic                        data_sel,
  output logic [N_CORES-1:0]          instr_en,
  output logic [N_CORES-1:0]          core_rst,
  output logic                        exec_done,
  output logic [N_CORES-1:0]          done_vec,
  output logic [CYC_W-1:0]            run_cycles,
  output logic [1:0]                  state
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int              HCW       = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_INIT = HCW'(RST_HOLD - 1);
  localparam logic [CYC_W-1:0] CYC_MAX  = '1;

  state_e             state_q, state_d;
  logic [N_CORES-1:0] mask_q, mask_d;
  logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [N_CORES-1:0] done_vec_q, done_vec_d;
  logic [CYC_W-1:0]   run_cycles_q, run_cycles_d;

  logic [N_CORES-1:0] status_done;
  logic [N_CORES-1:0] new_done;
  logic               all_done;
  logic               io_sel;
  logic               in_run;
  logic               unused_status;

  // Only bit 0 of each status word carries meaning; the rest is folded away.
  assign unused_status = ^core_status;

  // Pick out each core's exec-done flag from its status word.
  always_comb begin
    status_done = '0;
    for (int i = 0; i < N_CORES; i++) begin
      status_done[i] = core_status[i*STATUS_W];
    end
  end

  assign new_done = mask_q & status_done;
  assign all_done = (((done_vec_q | new_done) & mask_q) == mask_q);

  // Next-state logic; abort overrides every other transition on the same edge.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    hold_cnt_d   = hold_cnt_q;
    done_vec_d   = done_vec_q;
    run_cycles_d = run_cycles_q;
    if (abort) begin
      state_d    = S_LOAD;
      done_vec_d = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          // An empty mask would never complete, so the request is ignored.
          if (start && (core_mask != '0)) begin
            state_d      = S_HOLD;
            mask_d       = core_mask;
            hold_cnt_d   = HOLD_INIT;
            done_vec_d   = '0;
            run_cycles_d = '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q - HCW'(1);
          end
        end
        S_RUN: begin
          if (run_cycles_q != CYC_MAX) begin
            run_cycles_d = run_cycles_q + CYC_W'(1);
          end
          done_vec_d = done_vec_q | new_done;
          if (all_done) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // Require start to drop so a level-held start cannot relaunch a run.
          if (!start) begin
            state_d = S_LOAD;
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_LOAD;
      mask_q       <= '0;
      hold_cnt_q   <= '0;
      done_vec_q   <= '0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      hold_cnt_q   <= hold_cnt_d;
      done_vec_q   <= done_vec_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign io_sel     = (state_q == S_LOAD) || (state_q == S_DONE);
  assign in_run     = (state_q == S_RUN);
  assign rst        = ~rstn;
  assign instr_sel  = io_sel;
  assign data_sel   = io_sel;
  assign instr_en   = {N_CORES{io_sel}} | ({N_CORES{in_run}} & mask_q & core_en_instr_mem);
  assign core_rst   = ~({N_CORES{in_run}} & mask_q);
  assign exec_done  = (state_q == S_DONE);
  assign done_vec   = done_vec_q;
  assign run_cycles = run_cycles_q;
  assign state      = state_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with two cores and a 4-bit cycle counter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived constants per scenario.
module tb_core_run_ctrl;

  localparam int N  = 2;
  localparam int SW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [N-1:0]  core_mask;
  logic [N-1:0]  core_en_instr_mem;
  logic [N*SW-1:0] core_status;
  logic          rst;
  logic          instr_sel;
  logic          data_sel;
  logic [N-1:0]  instr_en;
  logic [N-1:0]  core_rst;
  logic          exec_done;
  logic [N-1:0]  done_vec;
  logic [CW-1:0] run_cycles;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_run_ctrl #(
    .N_CORES (N),
    .STATUS_W(SW),
    .RST_HOLD(4),
    .CYC_W   (CW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .abort            (abort),
    .core_mask        (core_mask),
    .core_en_instr_mem(core_en_instr_mem),
    .core_status      (core_status),
    .rst              (rst),
    .instr_sel        (instr_sel),
    .data_sel         (data_sel),
    .instr_en         (instr_en),
    .core_rst         (core_rst),
    .exec_done        (exec_done),
    .done_vec         (done_vec),
    .run_cycles       (run_cycles),
    .state            (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upper status bits are set to prove that only bit 0 is used.
  task automatic set_status(input logic c0, input logic c1);
    core_status = {7'h7f, c1, 7'h7f, c0};
  endtask

  // Launch a run with the given mask and step through the full HOLD phase.
  task automatic launch(input logic [N-1:0] m);
    core_mask = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    core_mask = '0; core_en_instr_mem = '0; set_status(1'b0, 1'b0);
    #1;
    check("rst_state",     32'(state), 0);
    check("rst_instr_sel", 32'(instr_sel), 1);
    check("rst_data_sel",  32'(data_sel), 1);
    check("rst_core_rst",  32'(core_rst), 2'b11);
    check("rst_exec_done", 32'(exec_done), 0);
    check("rst_done_vec",  32'(done_vec), 0);
    check("rst_cycles",    32'(run_cycles), 0);
    check("rst_out",       32'(rst), 1);
    tick(); tick();
    rstn = 1'b1;
    #1;
    check("rst_out_rel", 32'(rst), 0);

    // Full two-core run: HOLD lasts exactly four cycles.
    core_mask = 2'b11; start = 1'b1;
    core_en_instr_mem = 2'b01;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("hold_state", 32'(state), 1);
      check("hold_isel",  32'(instr_sel), 0);
      check("hold_crst",  32'(core_rst), 2'b11);
      tick();
    end
    check("run_state",  32'(state), 2);
    check("run_crst",   32'(core_rst), 2'b00);
    check("run_dsel",   32'(data_sel), 0);
    check("run_ien",    32'(instr_en), 2'b01);
    for (int c = 0; c < 8; c++) begin
      set_status(c == 3, c == 7);
      if (c == 7) start = 1'b1;
      tick();
      if (c == 3) check("dv_c3", 32'(done_vec), 2'b01);
      if (c == 5) check("dv_sticky", 32'(done_vec), 2'b01);
      if (c < 7) check("still_run", 32'(state), 2);
    end
    set_status(1'b0, 1'b0);
    check("done_state", 32'(state), 3);
    check("done_dv",    32'(done_vec), 2'b11);
    check("done_exec",  32'(exec_done), 1);
    check("done_isel",  32'(instr_sel), 1);
    check("done_cyc",   32'(run_cycles), 8);
    check("done_crst",  32'(core_rst), 2'b11);
    check("done_ien",   32'(instr_en), 2'b11);
    tick(); tick();
    check("done_hold_start", 32'(state), 3);
    start = 1'b0;
    tick();
    check("back_load",   32'(state), 0);
    check("load_keep_dv", 32'(done_vec), 2'b11);
    check("load_keep_cy", 32'(run_cycles), 8);

    // Single-core mask: core1 toggles but is ignored; mask change after handover ignored.
    core_mask = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    core_mask = 2'b11;
    check("m01_hold",  32'(state), 1);
    check("m01_dvclr", 32'(done_vec), 0);
    check("m01_cyclr", 32'(run_cycles), 0);
    repeat (4) tick();
    core_en_instr_mem = 2'b11;
    #1;
    check("m01_crst", 32'(core_rst), 2'b10);
    check("m01_ien",  32'(instr_en), 2'b01);
    for (int c = 0; c < 3; c++) begin
      set_status(c == 2, c[0] == 1'b0);
      tick();
      if (c < 2) begin
        check("m01_dv_ign", 32'(done_vec), 0);
        check("m01_run",    32'(state), 2);
      end
    end
    set_status(1'b0, 1'b0);
    check("m01_done", 32'(state), 3);
    check("m01_dv",   32'(done_vec), 2'b01);
    check("m01_cyc",  32'(run_cycles), 3);
    tick();
    check("m01_load", 32'(state), 0);

    // Abort on the same edge the last core finishes.
    launch(2'b11);
    check("ab_run", 32'(state), 2);
    set_status(1'b1, 1'b0);
    tick();
    check("ab_dv1", 32'(done_vec), 2'b01);
    set_status(1'b0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    set_status(1'b0, 1'b0);
    check("ab_state", 32'(state), 0);
    check("ab_dv",    32'(done_vec), 0);
    check("ab_exec",  32'(exec_done), 0);
    check("ab_cyc",   32'(run_cycles), 1);

    // Counter saturation over 20 RUN cycles.
    launch(2'b01);
    repeat (20) tick();
    check("sat_run", 32'(state), 2);
    check("sat_cyc", 32'(run_cycles), 15);
    set_status(1'b1, 1'b0);
    tick();
    set_status(1'b0, 1'b0);
    check("sat_done", 32'(state), 3);
    check("sat_cyc2", 32'(run_cycles), 15);
    tick();
    check("sat_load", 32'(state), 0);

    // Empty mask: the request is ignored and nothing changes.
    core_mask = 2'b00; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    check("m0_state", 32'(state), 0);
    check("m0_dv",    32'(done_vec), 2'b01);
    check("m0_cyc",   32'(run_cycles), 15);

    // Asynchronous reset in the middle of HOLD.
    core_mask = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    check("ar_hold", 32'(state), 1);
    #2 rstn = 1'b0;
    #1;
    check("ar_state", 32'(state), 0);
    check("ar_crst",  32'(core_rst), 2'b11);
    check("ar_isel",  32'(instr_sel), 1);
    check("ar_rst",   32'(rst), 1);
    check("ar_cyc",   32'(run_cycles), 0);
    check("ar_dv",    32'(done_vec), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
